// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sequencer for a small 8 x 4-bit register file.
//
// Executes one two-operand instruction per START (ADD, SUB, AND, LDI) by
// reading two registers, computing a result and writing it back, or clears
// all eight registers on CLEAR. The register file itself lives outside this
// block: it is read combinationally through rp_o/rq_o -> datap_i/dataq_i and
// written through wr_o/wa_o/ld_data_o.
//
// Ports
//   clk_i      rising-edge clock
//   clr_i      asynchronous active-high reset
//   start_i    execute one instruction (sampled in IDLE only)
//   clear_i    zero all registers (sampled in IDLE only, wins over start_i)
//   op_i       00 ADD, 01 SUB, 10 AND, 11 LDI
//   rd_i       destination register
//   rs_i/rt_i  source-P / source-Q registers
//   imm_i      immediate for LDI
//   datap_i    register-file read data for rp_o
//   dataq_i    register-file read data for rq_o
//   rp_o/rq_o  register-file read addresses
//   wa_o       register-file write address
//   wr_o       register-file write enable
//   ld_data_o  register-file write data
//   busy_o     high in every state except IDLE
//   done_o     one-cycle completion pulse (registered)
//   result_o   last computed value
//   carry_o    carry/borrow of the last instruction
//   zero_o     result==0 of the last instruction
//   state_o    current FSM state, for debug and checkers
//
// Handshake: start_i/clear_i are single-cycle requests accepted only when
// busy_o is low; requests seen while busy_o is high are dropped, not queued.
// Completion is signalled by done_o for exactly one cycle, after which the
// block is idle again.

module regfile_ctrl (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       start_i,
    input  logic       clear_i,
    input  logic [1:0] op_i,
    input  logic [2:0] rd_i,
    input  logic [2:0] rs_i,
    input  logic [2:0] rt_i,
    input  logic [3:0] imm_i,
    input  logic [3:0] datap_i,
    input  logic [3:0] dataq_i,
    output logic [2:0] rp_o,
    output logic [2:0] rq_o,
    output logic [2:0] wa_o,
    output logic       wr_o,
    output logic [3:0] ld_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] result_o,
    output logic       carry_o,
    output logic       zero_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        CLRW  = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    state_t     state_q;
    logic [1:0] op_q;
    logic [2:0] rd_q;
    logic [3:0] imm_q;
    logic [2:0] rp_q;      // doubles as latched RS; holds outside READ
    logic [2:0] rq_q;      // doubles as latched RT; holds outside READ
    logic [2:0] cnt_q;     // CLRW write address
    logic [3:0] result_q;
    logic       carry_q;
    logic       zero_q;
    logic       done_q;

    logic [3:0] result_d;
    logic       carry_d;
    logic [4:0] sum;
    logic [4:0] diff;

    // ALU on the live read data; only sampled during EXEC.
    always_comb begin
        sum      = {1'b0, datap_i} + {1'b0, dataq_i};
        // A 5-bit subtraction wraps into bit 4 exactly when A < B.
        diff     = {1'b0, datap_i} - {1'b0, dataq_i};
        result_d = 4'd0;
        carry_d  = 1'b0;
        case (op_q)
            OP_ADD: begin
                result_d = sum[3:0];
                carry_d  = sum[4];
            end
            OP_SUB: begin
                result_d = diff[3:0];
                carry_d  = diff[4];
            end
            OP_AND: result_d = datap_i & dataq_i;
            OP_LDI: result_d = imm_q;
            default: result_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            rd_q     <= 3'd0;
            imm_q    <= 4'd0;
            rp_q     <= 3'd0;
            rq_q     <= 3'd0;
            cnt_q    <= 3'd0;
            result_q <= 4'd0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_i) begin
                        cnt_q   <= 3'd0;
                        state_q <= CLRW;
                    end else if (start_i) begin
                        op_q    <= op_i;
                        rd_q    <= rd_i;
                        imm_q   <= imm_i;
                        // Loading the read addresses here makes them valid
                        // for the whole of READ and EXEC.
                        rp_q    <= rs_i;
                        rq_q    <= rt_i;
                        state_q <= READ;
                    end
                end
                READ: state_q <= EXEC;
                EXEC: begin
                    result_q <= result_d;
                    carry_q  <= carry_d;
                    zero_q   <= (result_d == 4'd0);
                    state_q  <= WRITE;
                end
                WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= FIN;
                end
                CLRW: begin
                    cnt_q <= cnt_q + 3'd1;  // wraps back to 0 after 7
                    if (cnt_q == 3'd7) begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write-port decode straight from state so an asynchronous reset drops
    // wr_o immediately.
    always_comb begin
        wr_o      = 1'b0;
        wa_o      = 3'd0;
        ld_data_o = 4'd0;
        if (state_q == WRITE) begin
            wr_o      = 1'b1;
            wa_o      = rd_q;
            ld_data_o = result_q;
        end else if (state_q == CLRW) begin
            wr_o      = 1'b1;
            wa_o      = cnt_q;
        end
    end

    assign rp_o     = rp_q;
    assign rq_o     = rq_q;
    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign zero_o   = zero_q;
    assign state_o  = state_q;

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 CLR  input  1  asynchronous, active-high reset of all state.
REQ-004 START  input  1  request to execute one instruction; sampled in IDLE only.
REQ-005 CLEAR  input  1  request to zero all 8 registers; sampled in IDLE only.
REQ-006 OP  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 LDI.
REQ-007 RD, RS, RT  input  3 each  destination, source-P and source-Q register addresses.
REQ-008 IMM  input  4  immediate value for LDI.
REQ-009 RP, RQ  output  3 each  register-file read addresses.
REQ-010 WA  output  3  register-file write address.
REQ-011 WR  output  1  register-file write enable.
REQ-012 LD_DATA  output  4  register-file write data.
REQ-013 DATAP, DATAQ  input  4 each  combinational register-file read data for RP and RQ.
REQ-014 BUSY  output  1  high in every state except IDLE.
REQ-015 DONE  output  1  one-cycle completion pulse.
REQ-016 RESULT  output  4  last computed or written value.
REQ-017 CARRY, ZERO  output  1 each  flags of the last instruction.

Function
REQ-018 FSM states SHALL be IDLE, READ, EXEC, WRITE, CLRW, FIN.
REQ-019 In IDLE, CLEAR=1 SHALL go to CLRW; else START=1 SHALL go to READ; else stay in IDLE.
REQ-020 CLEAR SHALL win over START when both are high in IDLE.
REQ-021 On START acceptance, OP/RD/RS/RT/IMM SHALL be latched; later input changes SHALL have no effect.
REQ-022 READ SHALL drive RP=RS and RQ=RT, and go to EXEC.
REQ-023 EXEC SHALL capture DATAP as A and DATAQ as B, compute the result, and go to WRITE.
REQ-024 ADD: result=(A+B) mod 16; CARRY=bit 4 of the 5-bit sum.
REQ-025 SUB: result=(A-B) mod 16; CARRY=1 iff A<B (borrow).
REQ-026 AND: result=A&B; CARRY=0.
REQ-027 LDI: result=IMM; CARRY=0; DATAP/DATAQ ignored.
REQ-028 For all ops, ZERO=1 iff result==0.
REQ-029 RESULT, CARRY and ZERO SHALL update at the EXEC->WRITE edge and hold until the next EXEC.
REQ-030 WRITE SHALL assert WR=1, WA=latched RD and LD_DATA=result for exactly one cycle, then go to FIN.
REQ-031 FIN SHALL assert DONE=1 for one cycle, then go to IDLE.
REQ-032 Latency: START sampled at edge k gives READ in cycle k+1, EXEC k+2, WRITE k+3, DONE in k+4; BUSY is high k+1..k+4.
REQ-033 CLRW SHALL use a 3-bit counter starting at 0 and assert WR=1, WA=counter, LD_DATA=0 for 8 consecutive cycles (WA 0..7).
REQ-034 After the WA=7 cycle, CLRW SHALL go to FIN; CLEAR SHALL leave RESULT/CARRY/ZERO unchanged.
REQ-035 WR SHALL be 0 in every state other than WRITE and CLRW.
REQ-036 Outside WRITE and CLRW, WA and LD_DATA SHALL be 0.
REQ-037 Outside READ, RP and RQ SHALL hold their last values.
REQ-038 START or CLEAR asserted while BUSY=1 SHALL be ignored and not queued.
REQ-039 RD equal to RS or RT SHALL work: operands are read before the write.
REQ-040 DONE SHALL be registered; all other outputs are decoded from state and registers.

Reset
REQ-041 CLR=1 SHALL immediately force IDLE, zero the counter, latched fields and RESULT, and drive WR=0, DONE=0, BUSY=0, CARRY=0, ZERO=0, RP=RQ=WA=LD_DATA=0.
REQ-042 CLR asserted mid-WRITE or mid-CLRW SHALL drop WR asynchronously and abort the sequence; no further writes SHALL occur.
REQ-043 The first START after CLR deasserts SHALL be accepted normally.

Verification
REQ-044 Register model R1=9, R2=8; ADD RD=3 RS=1 RT=2 -> one WR pulse WA=3 LD_DATA=1 in cycle k+3; RESULT=1, CARRY=1, ZERO=0; DONE in k+4.
REQ-045 R4=3, R5=5; SUB RD=6 RS=4 RT=5 -> LD_DATA=14, CARRY=1; then SUB RS=5 RT=5 -> LD_DATA=0, ZERO=1, CARRY=0.
REQ-046 LDI RD=7 IMM=10 -> WA=7 LD_DATA=10; then AND RS=7 RT=1 with R1=9 -> LD_DATA=8.
REQ-047 CLEAR and START high together in IDLE -> 8 WR cycles with WA 0..7 and LD_DATA=0, then DONE; the instruction is not executed.
REQ-048 START pulsed during READ and again during WRITE -> ignored; exactly one WR and one DONE.
REQ-049 CLR asserted during CLRW at WA=4 -> WR=0 at once, BUSY=0; registers 5..7 are never written.
